serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial ripple-borrow subtractor: the inverse-direction companion to the team's 4-bit ripple carry adder. It computes `x - y - b0` one bit per clock through a single full-subtractor cell, LSB first, under a start/done handshake. It sits beside the parallel adder in the arithmetic datapath and serves as a low-area subtract unit and as a reference model for the adder's results (`x + y - y == x`).

## Interface
Parameters:
- `WIDTH`, default 4: operand and result width in bits, must be ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`    input   1      rising-edge clock.
- `rst`    input   1      asynchronous, active-high reset.
- `start`  input   1      request; sampled on `clk` while not busy.
- `x`      input   WIDTH  minuend; sampled with `start`.
- `y`      input   WIDTH  subtrahend; sampled with `start`.
- `b0`     input   1      borrow-in; sampled with `start`.
- `busy`   output  1      high while a subtraction is in progress.
- `done`   output  1      one-cycle pulse; results valid.
- `diff`   output  WIDTH  `(x - y - b0) mod 2^WIDTH`.
- `bout`   output  1      final borrow: 1 iff `x < y + b0` (unsigned).
- `ovf`    output  1      signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE or DONE with `start=1`:
  - latch `x`, `y` and `b0` into operand shift registers and the borrow flop;
  - clear the bit counter;
  - go to SHIFT.
- IDLE or DONE with `start=0`: DONE goes to IDLE; IDLE stays in IDLE.
- SHIFT, each cycle:
  - `a`=x_sr[0], `b`=y_sr[0], `bi`=borrow;
  - `d = a^b^bi`; `bo = (~a&b) | (~(a^b)&bi)`;
  - shift `d` into the MSB of the result shift register; shift both operand registers right;
  - `borrow <= bo`; counter increments.
- SHIFT ends after counter reaches `WIDTH-1` (WIDTH shift cycles):
  - load `diff` from the result register (with the last bit) and `bout` from `bo`;
  - go to DONE.
- DONE lasts one cycle with `done=1`.
- `diff`, `bout` and `ovf` hold their values from completion until the next completion or reset. They never change during SHIFT.
- `start` is ignored while in SHIFT. There is no queueing.
- Counter width is `$clog2(WIDTH)`; it never wraps in operation.

## Timing
- `start` accepted at edge N.
- `busy=1` from after edge N through the last SHIFT cycle (WIDTH cycles).
- `done=1` in the cycle after edge N+WIDTH. Latency is WIDTH+1 edges from acceptance to the `done` cycle.
- Back-to-back: `start=1` during the DONE cycle is accepted, giving one result every WIDTH+1 cycles.
- `busy` is low in IDLE and DONE.
- Reset, asynchronous at any time including mid-SHIFT:
  - state goes to IDLE and the operation is aborted with no `done`;
  - `busy=0`, `done=0`, `diff=0`, `bout=0`, `ovf=0`;
  - all internal registers are cleared.
- Operand inputs only need to be valid in the cycle `start` is accepted.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - `ovf` port exists;
  - `ovf = (x[MSB] ^ y[MSB]) & (diff[MSB] ^ x[MSB])`, using the latched operand MSBs;
  - loaded with `diff`, reset to 0.
- Not defined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `serial_sub_pkg`:
  - state typedef (IDLE/SHIFT/DONE);
  - localparam encodings;
  - default `WIDTH` constant, shared with the adder bench.
- One sub-module, `full_subtractor` (inputs `a`, `b`, `bi`; outputs `d`, `bo`), holds the combinational bit cell. It is the subtract counterpart of the adder's full adder cell.
- The top module holds the FSM, counter, shift registers and output registers.

## Test plan
- WIDTH=4, x=9, y=3, b0=0 -> `done` 5 cycles after acceptance, `diff=6`, `bout=0`, `busy` high for exactly 4 cycles.
- x=3, y=9, b0=0 -> `diff=10`, `bout=1`. Then x=15, y=15, b0=1 -> `diff=15`, `bout=1`. Then x=0, y=0, b0=1 -> `diff=15`, `bout=1`.
- Exhaustive sweep of x, y ∈ 0..15 with b0 = (x==15) and `start` re-asserted in each DONE cycle -> every `diff`/`bout` matches `x - y - b0`, and results arrive every 5 cycles.
- `start` pulsed with x=1, y=1 during SHIFT of x=12, y=5 -> single `done`, `diff=7`, `bout=0`; the second request is ignored.
- `rst` asserted mid-SHIFT of x=7, y=2 -> outputs 0 immediately and no `done`. The next x=7, y=2 -> `diff=5`.
- With `SERIAL_SUB_OVF_EN`: x=8, y=1 -> `diff=7`, `ovf=1`; x=5, y=3 -> `ovf=0`.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the default operand width (also used by the adder bench).
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEFAULT = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor; ovf exists only when
// SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) ();

  // Handshake: start (with x/y/b0) is taken on any clk edge where busy=0.
  // busy is high for the WIDTH shift cycles; done pulses for one cycle when
  // diff/bout/ovf are updated, and those results hold until the next done.
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif
  state_t           dbg_state;

`ifdef SERIAL_SUB_OVF_EN
  modport master (output start, x, y, b0,
                  input  busy, done, diff, bout, ovf, dbg_state);
  modport slave  (input  start, x, y, b0,
                  output busy, done, diff, bout, ovf, dbg_state);
`else
  modport master (output start, x, y, b0,
                  input  busy, done, diff, bout, dbg_state);
  modport slave  (input  start, x, y, b0,
                  output busy, done, diff, bout, dbg_state);
`endif

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bi, bo = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor, LSB first, one bit per clock.
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_sr_q, x_sr_d;
  logic [WIDTH-1:0] y_sr_q, y_sr_d;
  logic [WIDTH-2:0] res_sr_q, res_sr_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             x_msb_q, x_msb_d;
  logic             y_msb_q, y_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] res_next;

  full_subtractor u_cell (
    .a  (x_sr_q[0]),
    .b  (y_sr_q[0]),
    .bi (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // The result register keeps only WIDTH-1 bits; the final bit comes
  // straight from the cell on the last shift cycle.
  assign res_next = {cell_d, res_sr_q};

  always_comb begin
    state_d  = state_q;
    x_sr_d   = x_sr_q;
    y_sr_d   = y_sr_q;
    res_sr_d = res_sr_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    x_msb_d  = x_msb_q;
    y_msb_d  = y_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          x_sr_d   = bus.x;
          y_sr_d   = bus.y;
          borrow_d = bus.b0;
          cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
          x_msb_d  = bus.x[WIDTH-1];
          y_msb_d  = bus.y[WIDTH-1];
`endif
          state_d  = ST_SHIFT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        res_sr_d = res_next[WIDTH-1:1];
        x_sr_d   = {1'b0, x_sr_q[WIDTH-1:1]};
        y_sr_d   = {1'b0, y_sr_q[WIDTH-1:1]};
        borrow_d = cell_bo;
        if (cnt_q == CNT_LAST) begin
          diff_d  = res_next;
          bout_d  = cell_bo;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (x_msb_q ^ y_msb_q) & (cell_d ^ x_msb_q);
`endif
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_sr_q   <= '0;
      y_sr_q   <= '0;
      res_sr_q <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      x_msb_q  <= 1'b0;
      y_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      x_sr_q   <= x_sr_d;
      y_sr_q   <= y_sr_d;
      res_sr_q <= res_sr_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      x_msb_q  <= x_msb_d;
      y_msb_q  <= y_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy      = (state_q == ST_SHIFT);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4); the overflow
// scenario runs only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Driver: presents one request, waits for done (bounded), reports what it saw.
  // Entered and left at #1 after a rising edge; left in the done cycle.
  task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                        input logic b0v, output logic [W-1:0] d,
                        output logic bo, output int lat, output int busy_n,
                        output bit held, output int done_cyc);
    logic [W-1:0] d0;
    logic         bo0;
    d0 = bus.diff;
    bo0 = bus.bout;
    d = 'x;
    bo = 1'bx;
    lat = 0;
    busy_n = 0;
    held = 1'b1;
    done_cyc = 0;
    bus.start = 1'b1;
    bus.x = xv;
    bus.y = yv;
    bus.b0 = b0v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.b0 = 1'b0;
    for (int i = 1; i <= 3 * W && lat == 0; i++) begin
      if (bus.done) begin
        lat = i;
        d = bus.diff;
        bo = bus.bout;
        done_cyc = cyc;
      end else begin
        if (bus.busy) busy_n++;
        if (bus.diff !== d0 || bus.bout !== bo0) held = 1'b0;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.b0 = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.diff !== 4'd0 || bus.bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_out diff=%0d bout=%b expected 0 0", bus.diff, bus.bout);
    end
    checks++;
    if (bus.dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state state=%0d expected %0d", bus.dbg_state, ST_IDLE);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf ovf=%b expected 0", bus.ovf);
    end
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [W-1:0] d;
    logic bo;
    int lat, busy_n, dc;
    bit held;
    run_op(4'd9, 4'd3, 1'b0, d, bo, lat, busy_n, held, dc);
    checks++;
    if (lat != W + 1) begin
      errors++;
      $display("FAIL basic_latency got=%0d expected %0d", lat, W + 1);
    end
    checks++;
    if (busy_n != W) begin
      errors++;
      $display("FAIL basic_busy_cycles got=%0d expected %0d", busy_n, W);
    end
    checks++;
    if (d !== 4'd6 || bo !== 1'b0) begin
      errors++;
      $display("FAIL basic_9m3 diff=%0d bout=%b expected 6 0", d, bo);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] tx[3] = '{4'd3, 4'd15, 4'd0};
    logic [W-1:0] ty[3] = '{4'd9, 4'd15, 4'd0};
    logic         tb0[3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] td[3] = '{4'd10, 4'd15, 4'd15};
    logic         tbo[3] = '{1'b1, 1'b1, 1'b1};
    logic [W-1:0] d;
    logic bo;
    int lat, busy_n, dc;
    bit held;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      run_op(tx[k], ty[k], tb0[k], d, bo, lat, busy_n, held, dc);
      checks++;
      if (d !== td[k] || bo !== tbo[k]) begin
        errors++;
        $display("FAIL directed_%0d diff=%0d bout=%b expected %0d %b", k, d, bo, td[k], tbo[k]);
      end
      checks++;
      if (!held) begin
        errors++;
        $display("FAIL directed_hold_%0d outputs changed during shift, expected held", k);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    logic bo;
    logic [W:0] exp_v;
    int lat, busy_n, dc, prev_dc;
    bit held;
    logic [W-1:0] xv, yv;
    logic b0v;
    prev_dc = -1;
    @(posedge clk);
    #1;
    for (int xi = 0; xi < 16; xi++) begin
      for (int yi = 0; yi < 16; yi++) begin
        xv = 4'(xi);
        yv = 4'(yi);
        b0v = (xi == 15);
        exp_q.push_back(5'(xi - yi - int'(b0v)));
        run_op(xv, yv, b0v, d, bo, lat, busy_n, held, dc);
        exp_v = exp_q.pop_front();
        checks++;
        if ({bo, d} !== exp_v) begin
          errors++;
          $display("FAIL sweep x=%0d y=%0d b0=%b diff=%0d bout=%b expected %0d %b",
                   xv, yv, b0v, d, bo, exp_v[W-1:0], exp_v[W]);
        end
        checks++;
        if (lat != W + 1) begin
          errors++;
          $display("FAIL sweep_latency x=%0d y=%0d got=%0d expected %0d", xv, yv, lat, W + 1);
        end
        if (prev_dc >= 0) begin
          checks++;
          if (dc - prev_dc != W + 1) begin
            errors++;
            $display("FAIL sweep_period x=%0d y=%0d got=%0d expected %0d", xv, yv, dc - prev_dc, W + 1);
          end
        end
        prev_dc = dc;
      end
    end
  endtask

  task automatic test_ignore_start();
    int done_n;
    logic [W-1:0] d;
    logic bo;
    done_n = 0;
    d = 'x;
    bo = 1'bx;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.x = 4'd12;
    bus.y = 4'd5;
    bus.b0 = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.x = 4'd1;
    bus.y = 4'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) begin
        done_n++;
        if (done_n == 1) begin
          d = bus.diff;
          bo = bus.bout;
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL ignore_done_count got=%0d expected 1", done_n);
    end
    checks++;
    if (d !== 4'd7 || bo !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result diff=%0d bout=%b expected 7 0", d, bo);
    end
  endtask

  task automatic test_reset_mid();
    int done_n;
    logic [W-1:0] d;
    logic bo;
    int lat, busy_n, dc;
    bit held;
    done_n = 0;
    bus.start = 1'b1;
    bus.x = 4'd7;
    bus.y = 4'd2;
    bus.b0 = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre busy=%b expected 1", bus.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 4'd0 || bus.bout !== 1'b0) begin
      errors++;
      $display("FAIL midreset_out busy=%b done=%b diff=%0d bout=%b expected 0 0 0 0",
               bus.busy, bus.done, bus.diff, bus.bout);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) done_n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (done_n != 0) begin
      errors++;
      $display("FAIL midreset_no_done got=%0d expected 0", done_n);
    end
    run_op(4'd7, 4'd2, 1'b0, d, bo, lat, busy_n, held, dc);
    checks++;
    if (d !== 4'd5 || bo !== 1'b0 || lat != W + 1) begin
      errors++;
      $display("FAIL midreset_rerun diff=%0d bout=%b lat=%0d expected 5 0 %0d", d, bo, lat, W + 1);
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] d;
    logic bo;
    int lat, busy_n, dc;
    bit held;
    @(posedge clk);
    #1;
    run_op(4'd8, 4'd1, 1'b0, d, bo, lat, busy_n, held, dc);
    checks++;
    if (d !== 4'd7 || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_8m1 diff=%0d ovf=%b expected 7 1", d, bus.ovf);
    end
    run_op(4'd5, 4'd3, 1'b0, d, bo, lat, busy_n, held, dc);
    checks++;
    if (d !== 4'd2 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_5m3 diff=%0d ovf=%b expected 2 0", d, bus.ovf);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
